// File: rtl/pmod_cls_spi_responder.sv
// SPI mode-0 receiver for a PmodCLS-style character LCD: bytes are assembled from the
// synchronized SPI pins and fed to an ANSI escape parser that maintains a 2x16 text buffer.
module pmod_cls_spi_responder #(
    parameter int parm_sync_stages = 2
) (
    input  logic         i_ext_spi_clk_x,
    input  logic         i_srst,
    input  logic         i_sck,
    input  logic         i_csn,
    input  logic         i_copi,
    output logic [7:0]   o_rx_byte,
    output logic         o_rx_byte_valid,
    output logic         o_frame_err,
    output logic         o_cmd_clear,
    output logic [127:0] o_dat_ascii_line1,
    output logic [127:0] o_dat_ascii_line2,
    output logic         o_cursor_row,
    output logic [4:0]   o_cursor_col
);

    typedef enum logic [2:0] {
        ST_CHR,
        ST_ESC,
        ST_CSI,
        ST_ARG1,
        ST_ARG2
    } state_t;

    localparam logic [127:0] BLANK_LINE = {16{8'h20}};

    logic [parm_sync_stages-1:0] sck_sync;
    logic [parm_sync_stages-1:0] csn_sync;
    logic [parm_sync_stages-1:0] copi_sync;
    logic       sck_s, csn_s, copi_s;
    logic       sck_d, csn_d;
    logic       sck_rise, csn_rise, shift_en;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    state_t     state, state_nx;
    logic [6:0] arg1, arg2, arg1_nx, arg2_nx;
    logic       do_write, do_clear, do_cursor;
    logic [6:0] wr_lsb;

    assign sck_s  = sck_sync[parm_sync_stages-1];
    assign csn_s  = csn_sync[parm_sync_stages-1];
    assign copi_s = copi_sync[parm_sync_stages-1];

    assign sck_rise = sck_s & ~sck_d;
    assign csn_rise = csn_s & ~csn_d;
    // An sck edge seen in the same cycle as the csn rise still counts, so a
    // byte whose last bit races the chip-select release is not lost.
    assign shift_en = sck_rise & (~csn_s | csn_rise);

    always_ff @(posedge i_ext_spi_clk_x or posedge i_srst) begin
        if (i_srst) begin
            sck_sync        <= '0;
            csn_sync        <= '1;
            copi_sync       <= '0;
            sck_d           <= 1'b0;
            csn_d           <= 1'b1;
            bit_cnt         <= 3'd0;
            shreg           <= 8'h00;
            o_rx_byte       <= 8'h00;
            o_rx_byte_valid <= 1'b0;
            o_frame_err     <= 1'b0;
        end else begin
            sck_sync        <= {sck_sync[parm_sync_stages-2:0], i_sck};
            csn_sync        <= {csn_sync[parm_sync_stages-2:0], i_csn};
            copi_sync       <= {copi_sync[parm_sync_stages-2:0], i_copi};
            sck_d           <= sck_s;
            csn_d           <= csn_s;
            o_rx_byte_valid <= 1'b0;
            o_frame_err     <= 1'b0;
            if (shift_en && bit_cnt == 3'd7) begin
                o_rx_byte       <= {shreg[6:0], copi_s};
                o_rx_byte_valid <= 1'b1;
            end
            if (csn_rise && bit_cnt != 3'd0 && !(shift_en && bit_cnt == 3'd7)) begin
                o_frame_err <= 1'b1;
            end
            if (csn_s) begin
                bit_cnt <= 3'd0;
                shreg   <= 8'h00;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], copi_s};
            end
        end
    end

    // Decimal accumulate; anything already >= 10 would pass 99 after the multiply.
    function automatic logic [6:0] acc_digit(input logic [6:0] a, input logic [7:0] b);
        if (a >= 7'd10) return 7'd99;
        return (a * 7'd10) + {3'b000, b[3:0]};
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    always_comb begin
        state_nx  = state;
        arg1_nx   = arg1;
        arg2_nx   = arg2;
        do_write  = 1'b0;
        do_clear  = 1'b0;
        do_cursor = 1'b0;
        if (o_rx_byte_valid) begin
            case (state)
                ST_CHR: begin
                    if (o_rx_byte == 8'h1B) begin
                        state_nx = ST_ESC;
                    end else if (o_rx_byte >= 8'h20 && o_rx_byte <= 8'h7E) begin
                        do_write = ~o_cursor_col[4];
                    end
                end
                ST_ESC: begin
                    if (o_rx_byte == 8'h5B) begin
                        state_nx = ST_CSI;
                        arg1_nx  = 7'd0;
                        arg2_nx  = 7'd0;
                    end else if (o_rx_byte != 8'h1B) begin
                        state_nx = ST_CHR;
                    end
                end
                ST_CSI, ST_ARG1: begin
                    if (is_digit(o_rx_byte)) begin
                        arg1_nx  = acc_digit(arg1, o_rx_byte);
                        state_nx = ST_ARG1;
                    end else if (o_rx_byte == 8'h3B) begin
                        state_nx = ST_ARG2;
                    end else if (o_rx_byte == 8'h6A) begin
                        do_clear = 1'b1;
                        state_nx = ST_CHR;
                    end else if (o_rx_byte == 8'h48) begin
                        do_cursor = 1'b1;
                        state_nx  = ST_CHR;
                    end else if (o_rx_byte == 8'h1B) begin
                        state_nx = ST_ESC;
                    end else begin
                        state_nx = ST_CHR;
                    end
                end
                ST_ARG2: begin
                    if (is_digit(o_rx_byte)) begin
                        arg2_nx = acc_digit(arg2, o_rx_byte);
                    end else if (o_rx_byte == 8'h48) begin
                        do_cursor = 1'b1;
                        state_nx  = ST_CHR;
                    end else if (o_rx_byte == 8'h6A) begin
                        do_clear = 1'b1;
                        state_nx = ST_CHR;
                    end else if (o_rx_byte == 8'h1B) begin
                        state_nx = ST_ESC;
                    end else begin
                        state_nx = ST_CHR;
                    end
                end
                default: state_nx = ST_CHR;
            endcase
        end
    end

    // Column 0 sits in the top byte, so the write slot is (15 - col) * 8.
    assign wr_lsb = {~o_cursor_col[3:0], 3'b000};

    always_ff @(posedge i_ext_spi_clk_x or posedge i_srst) begin
        if (i_srst) begin
            state             <= ST_CHR;
            arg1              <= 7'd0;
            arg2              <= 7'd0;
            o_cmd_clear       <= 1'b0;
            o_dat_ascii_line1 <= BLANK_LINE;
            o_dat_ascii_line2 <= BLANK_LINE;
            o_cursor_row      <= 1'b0;
            o_cursor_col      <= 5'd0;
        end else begin
            state       <= state_nx;
            arg1        <= arg1_nx;
            arg2        <= arg2_nx;
            o_cmd_clear <= do_clear;
            if (do_clear) begin
                o_dat_ascii_line1 <= BLANK_LINE;
                o_dat_ascii_line2 <= BLANK_LINE;
                o_cursor_row      <= 1'b0;
                o_cursor_col      <= 5'd0;
            end else if (do_cursor) begin
                o_cursor_row <= (arg1 >= 7'd1);
                o_cursor_col <= (arg2 > 7'd15) ? 5'd15 : arg2[4:0];
            end else if (do_write) begin
                if (o_cursor_row) o_dat_ascii_line2[wr_lsb +: 8] <= o_rx_byte;
                else              o_dat_ascii_line1[wr_lsb +: 8] <= o_rx_byte;
                o_cursor_col <= o_cursor_col + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Directed bench for pmod_cls_spi_responder: SPI byte driver, received-byte scoreboard,
// and hand-computed expectations for the text buffer, cursor and event pulses.
module tb_pmod_cls_spi_responder;

    localparam logic [127:0] BLANK = {16{8'h20}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sck = 1'b0;
    logic         csn = 1'b1;
    logic         copi = 1'b0;
    logic [7:0]   rx_byte;
    logic         rx_byte_valid;
    logic         frame_err;
    logic         cmd_clear;
    logic [127:0] line1;
    logic [127:0] line2;
    logic         cursor_row;
    logic [4:0]   cursor_col;

    int tests = 0;
    int failed = 0;
    int n_valid = 0;
    int n_clear = 0;
    int n_ferr = 0;
    int v0, c0, f0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    pmod_cls_spi_responder #(.parm_sync_stages(2)) dut (
        .i_ext_spi_clk_x   (clk),
        .i_srst            (rst),
        .i_sck             (sck),
        .i_csn             (csn),
        .i_copi            (copi),
        .o_rx_byte         (rx_byte),
        .o_rx_byte_valid   (rx_byte_valid),
        .o_frame_err       (frame_err),
        .o_cmd_clear       (cmd_clear),
        .o_dat_ascii_line1 (line1),
        .o_dat_ascii_line2 (line2),
        .o_cursor_row      (cursor_row),
        .o_cursor_col      (cursor_col)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard and event counters, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_byte_valid) begin
                n_valid++;
                if (exp_q.size() == 0) check("rx_unexpected_qsize", 128'(exp_q.size()), 128'd1);
                else                   check("rx_byte", {120'd0, rx_byte}, {120'd0, exp_q.pop_front()});
            end
            if (cmd_clear) n_clear++;
            if (frame_err) n_ferr++;
        end
    end

    // driver tasks
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            copi = b[i];
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
    endtask

    task automatic send_frame();
        csn = 1'b0;
        #40;
        while (tx_q.size() > 0) begin
            logic [7:0] b;
            b = tx_q.pop_front();
            exp_q.push_back(b);
            send_bits(b, 8);
        end
        #40 csn = 1'b1;
        #100;
    endtask

    task automatic snap();
        v0 = n_valid;
        c0 = n_clear;
        f0 = n_ferr;
    endtask

    initial begin
        #100;
        check("rst_rx_byte", {120'd0, rx_byte}, 128'd0);
        check("rst_valid", {127'd0, rx_byte_valid}, 128'd0);
        check("rst_ferr", {127'd0, frame_err}, 128'd0);
        check("rst_clear", {127'd0, cmd_clear}, 128'd0);
        check("rst_line1", line1, BLANK);
        check("rst_line2", line2, BLANK);
        check("rst_row", {127'd0, cursor_row}, 128'd0);
        check("rst_col", {123'd0, cursor_col}, 128'd0);
        rst = 1'b0;
        #50;

        // plain text on line 1
        tx_q = '{8'h58, 8'h59};
        send_frame();
        check("xy_line1", line1, {16'h5859, {14{8'h20}}});
        check("xy_col", {123'd0, cursor_col}, 128'd2);

        // ESC [ 0 j clears
        snap();
        tx_q = '{8'h1B, 8'h5B, 8'h30, 8'h6A};
        send_frame();
        check("clr_valid_cnt", 128'(n_valid - v0), 128'd4);
        check("clr_clear_cnt", 128'(n_clear - c0), 128'd1);
        check("clr_line1", line1, BLANK);
        check("clr_line2", line2, BLANK);
        check("clr_row", {127'd0, cursor_row}, 128'd0);
        check("clr_col", {123'd0, cursor_col}, 128'd0);

        // ESC [ 1 ; 0 0 H then a full line of text
        tx_q = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h30, 8'h30, 8'h48};
        for (int i = 0; i < 16; i++) tx_q.push_back(8'(8'h41 + i));
        send_frame();
        check("l2_line2", line2, 128'h4142434445464748494A4B4C4D4E4F50);
        check("l2_line1", line1, BLANK);
        check("l2_row", {127'd0, cursor_row}, 128'd1);
        check("l2_col", {123'd0, cursor_col}, 128'd16);

        // past end of line: discarded
        tx_q = '{8'h51};
        send_frame();
        check("q_line2", line2, 128'h4142434445464748494A4B4C4D4E4F50);
        check("q_col", {123'd0, cursor_col}, 128'd16);

        // ESC [ 7 ; 2 5 H -> row 1, col clamped to 15
        tx_q = '{8'h1B, 8'h5B, 8'h37, 8'h3B, 8'h32, 8'h35, 8'h48};
        send_frame();
        check("cur_row", {127'd0, cursor_row}, 128'd1);
        check("cur_col", {123'd0, cursor_col}, 128'd15);

        // partial byte then a good one
        snap();
        csn = 1'b0;
        #40;
        send_bits(8'hFF, 5);
        #40 csn = 1'b1;
        #100;
        tx_q = '{8'h41};
        send_frame();
        check("ferr_cnt", 128'(n_ferr - f0), 128'd1);
        check("ferr_line2", line2, 128'h4142434445464748494A4B4C4D4E4F41);
        check("ferr_col", {123'd0, cursor_col}, 128'd16);

        // saturating args, ignored control byte, ESC + non-'[' back to text
        tx_q = '{8'h0A, 8'h1B, 8'h5B, 8'h31, 8'h32, 8'h33, 8'h3B, 8'h39, 8'h39, 8'h39, 8'h48,
                 8'h1B, 8'h41, 8'h5A};
        send_frame();
        check("sat_line2", line2, 128'h4142434445464748494A4B4C4D4E4F5A);
        check("sat_row", {127'd0, cursor_row}, 128'd1);
        check("sat_col", {123'd0, cursor_col}, 128'd16);

        // ESC ESC [ 2 ; j clears from the second-argument state
        snap();
        tx_q = '{8'h1B, 8'h1B, 8'h5B, 8'h32, 8'h3B, 8'h6A};
        send_frame();
        check("clr2_cnt", 128'(n_clear - c0), 128'd1);
        check("clr2_line2", line2, BLANK);
        check("clr2_col", {123'd0, cursor_col}, 128'd0);

        // text on line 2 so the reset has something to wipe
        tx_q = '{8'h1B, 8'h5B, 8'h31, 8'h48, 8'h4B};
        send_frame();
        check("pre_rst_line2", line2, {8'h4B, {15{8'h20}}});

        // reset after bit 3 of a byte, mid-frame
        snap();
        csn = 1'b0;
        #40;
        send_bits(8'hA5, 3);
        rst = 1'b1;
        #30;
        check("mid_rst_line2", line2, BLANK);
        rst = 1'b0;
        #50 csn = 1'b1;
        #100;
        tx_q = '{8'h1B, 8'h5B, 8'h48, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        send_frame();
        check("post_rst_line1", line1, {40'h48454C4C4F, {11{8'h20}}});
        check("post_rst_row", {127'd0, cursor_row}, 128'd0);
        check("post_rst_col", {123'd0, cursor_col}, 128'd5);
        check("post_rst_ferr_cnt", 128'(n_ferr - f0), 128'd0);

        check("exp_q_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pmod_cls_spi_responder.md
PMOD_CLS_SPI_RESPONDER -- requirements
Module: pmod_cls_spi_responder

Interface
REQ-001 parm_sync_stages, 2, synchronizer depth for i_sck, i_csn and i_copi; legal values 2-3.
REQ-002 i_ext_spi_clk_x  in  1  system clock; the only clock, all logic on its rising edge.
REQ-003 i_srst  in  1  reset, asynchronous assert, active-high.
REQ-004 i_sck  in  1  SPI clock from the CLS driver, mode 0, asynchronous to i_ext_spi_clk_x.
REQ-005 i_csn  in  1  SPI chip select, active-low.
REQ-006 i_copi  in  1  SPI data, MSB first.
REQ-007 o_rx_byte  out  8  last received byte.
REQ-008 o_rx_byte_valid  out  1  one-cycle pulse when o_rx_byte updates.
REQ-009 o_frame_err  out  1  one-cycle pulse when i_csn rises with 1-7 bits pending.
REQ-010 o_cmd_clear  out  1  one-cycle pulse when a clear-display sequence completes.
REQ-011 o_dat_ascii_line1  out  128  line 1 text; column 0 in bits 127:120, column 15 in bits 7:0.
REQ-012 o_dat_ascii_line2  out  128  line 2 text; same layout.
REQ-013 o_cursor_row  out  1  cursor row, 0 = line 1.
REQ-014 o_cursor_col  out  5  cursor column, 0-16; 16 = past end of line.

Function
REQ-015 i_sck, i_csn and i_copi shall each pass through parm_sync_stages flops; all edge detection uses the synchronized copies.
REQ-016 While synchronized csn is high, the bit counter and shift register shall hold at 0.
REQ-017 On each synchronized sck rising edge with csn low, the block shall shift synchronized copi into the LSB and increment the 3-bit bit counter.
REQ-018 On the 8th bit, o_rx_byte shall load the assembled byte, o_rx_byte_valid shall pulse on the next clock, and the bit counter shall wrap to 0. Multi-byte frames shall be supported without csn toggling.
REQ-019 If csn rises with bit counter 1-7, o_frame_err shall pulse one cycle, the partial byte shall be discarded, and the parser state shall be unchanged.
REQ-020 The parser FSM states are ST_CHR, ST_ESC, ST_CSI, ST_ARG1 and ST_ARG2. It shall advance only in cycles where o_rx_byte_valid=1, and buffer and cursor updates shall be visible on the clock after the pulse.
REQ-021 ST_CHR transitions:
- 0x1B -> ST_ESC.
- 0x20-0x7E with col<16 -> write the byte at (row,col), col+1.
- 0x20-0x7E with col=16 -> discard.
- Any other byte -> ignore.
REQ-022 ST_ESC transitions:
- 0x5B -> ST_CSI, arg1=0, arg2=0.
- 0x1B -> stay in ST_ESC.
- Any other byte -> ST_CHR.
REQ-023 ST_CSI and ST_ARG1 transitions:
- Digit 0x30-0x39 -> arg1=arg1*10+digit, saturating at 99, -> ST_ARG1.
- 0x3B -> ST_ARG2.
- 'j' (0x6A) -> clear.
- 'H' (0x48) -> cursor set.
- 0x1B -> ST_ESC.
- Any other byte -> ST_CHR.
REQ-024 ST_ARG2 transitions:
- Digit -> arg2 accumulates, saturating at 99.
- 'H' -> cursor set.
- 'j' -> clear.
- 0x1B -> ST_ESC.
- Any other byte -> ST_CHR.
REQ-025 Clear shall set all 32 characters to 0x20, set row=0 and col=0, pulse o_cmd_clear, and go to ST_CHR; arguments are ignored.
REQ-026 Cursor set shall apply row=(arg1>=1), col=min(arg2,15), then go to ST_CHR.
REQ-027 arg1 and arg2 are 7-bit registers; saturation applies before the multiply overflows.
REQ-028 A byte completing in the same cycle as a csn rise shall be treated as complete: valid pulse, no frame error.

Reset
REQ-029 While i_srst is high, the following shall hold:
- All synchronizer flops, bit counter and shift register at 0; synchronizer csn flops at 1.
- o_rx_byte=0x00; o_rx_byte_valid, o_frame_err and o_cmd_clear at 0.
- Both lines all 0x20; row=0, col=0; FSM in ST_CHR; arg1=arg2=0.
REQ-030 Reset asserted mid-byte or mid-sequence shall abandon it. After deassertion, reception shall restart only at the next csn falling edge or sck rising edge with csn low.

Verification
REQ-031 Send 1B 5B 30 6A in one csn frame -> o_rx_byte_valid pulses 4 times, o_cmd_clear pulses once, both lines are all 0x20, row=0, col=0.
REQ-032 Send 1B 5B 31 3B 30 30 48, then "ABCDEFGHIJKLMNOP" -> o_dat_ascii_line2 = 0x4142...50, line1 unchanged, col=16.
REQ-033 After REQ-032, send 'Q' -> line2 unchanged, col stays 16.
REQ-034 Send 1B 5B 37 3B 32 35 48 -> row=1, col=15.
REQ-035 Clock 5 bits of 0xFF then raise csn, then send 0x41 -> o_frame_err pulses once, the next byte is received as 0x41 and written at the cursor.
REQ-036 Assert i_srst after bit 3 of a byte mid-frame, release, then send a full line-1 sequence plus text -> line1 is correct, no frame error pulse.
